// File: rtl/memory_io_arbiter.sv
// Round-robin arbiter sharing the memory_io port between the CPU (port 0) and DMA (port 1),
// with read-return tagging and priming reads ahead of IO writes.
module memory_io_arbiter (
    input  logic        main_clk,
    input  logic        main_reset,
    input  logic        p0_req,
    input  logic        p1_req,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p1_addr,
    input  logic [15:0] p0_wdata,
    input  logic [15:0] p1_wdata,
    input  logic [1:0]  p0_ctrl,
    input  logic [1:0]  p1_ctrl,
    output logic        p0_ack,
    output logic        p1_ack,
    output logic        p0_rvalid,
    output logic        p1_rvalid,
    output logic [15:0] p0_rdata,
    output logic [15:0] p1_rdata,
    output logic [31:0] address_io,
    output logic [15:0] data_in_io,
    output logic [1:0]  control_io,
    input  logic [15:0] data_out_io
);

    function automatic logic is_io_write(input logic [31:0] addr, input logic [1:0] ctrl);
        return addr[31] & ctrl[1];
    endfunction

    logic        last_r;
    logic        h2_r;
    logic        lock_r;
    logic        lock_owner_r;
    logic [1:0]  tag0_r;
    logic [1:0]  tag1_r;
    logic [1:0]  tag2_r;

    logic        win_valid_s;
    logic        win_port_s;
    logic [31:0] win_addr_s;
    logic [15:0] win_wdata_s;
    logic [1:0]  win_ctrl_s;
    logic        blocked_s;
    logic        accept_s;

    // Winner selection: a held lock overrides round-robin until its owner is acked.
    always_comb begin
        win_valid_s = 1'b0;
        win_port_s  = 1'b0;
        if (lock_r) begin
            win_port_s  = lock_owner_r;
            win_valid_s = lock_owner_r ? p1_req : p0_req;
        end else if (p0_req && p1_req) begin
            win_valid_s = 1'b1;
            win_port_s  = ~last_r;
        end else if (p0_req) begin
            win_valid_s = 1'b1;
            win_port_s  = 1'b0;
        end else if (p1_req) begin
            win_valid_s = 1'b1;
            win_port_s  = 1'b1;
        end else begin
            win_valid_s = 1'b0;
            win_port_s  = 1'b0;
        end
    end

    // Field mux and the priming gate: an IO write needs bit31 high on the bus one cycle back.
    always_comb begin
        win_addr_s  = win_port_s ? p1_addr  : p0_addr;
        win_wdata_s = win_port_s ? p1_wdata : p0_wdata;
        win_ctrl_s  = win_port_s ? p1_ctrl  : p0_ctrl;
        blocked_s   = win_valid_s & is_io_write(win_addr_s, win_ctrl_s) & ~h2_r;
        accept_s    = win_valid_s & ~blocked_s;
        p0_ack      = accept_s & ~win_port_s;
        p1_ack      = accept_s &  win_port_s;
    end

    // Bus registers, grant pointer and priming lock.
    always_ff @(posedge main_clk) begin
        if (main_reset) begin
            address_io   <= 32'h0000_0000;
            data_in_io   <= 16'h0000;
            control_io   <= 2'b00;
            tag0_r       <= 2'b00;
            h2_r         <= 1'b0;
            lock_r       <= 1'b0;
            lock_owner_r <= 1'b0;
            last_r       <= 1'b1;
        end else begin
            h2_r <= address_io[31];
            if (accept_s) begin
                address_io <= win_addr_s;
                data_in_io <= win_wdata_s;
                control_io <= win_ctrl_s;
                tag0_r     <= {~win_ctrl_s[1], win_port_s};
                last_r     <= win_port_s;
                lock_r     <= 1'b0;
            end else if (blocked_s) begin
                // Priming cycle: present the write's address as a discarded read.
                address_io   <= win_addr_s;
                control_io   <= 2'b00;
                tag0_r       <= {1'b0, win_port_s};
                lock_r       <= 1'b1;
                lock_owner_r <= win_port_s;
            end else begin
                control_io <= 2'b00;
                tag0_r     <= 2'b00;
                lock_r     <= 1'b0;
            end
        end
    end

    // Tag stages tracking memory_io's two internal read-latency registers.
    always_ff @(posedge main_clk) begin
        if (main_reset) begin
            tag1_r <= 2'b00;
            tag2_r <= 2'b00;
        end else begin
            tag1_r <= tag0_r;
            tag2_r <= tag1_r;
        end
    end

    assign p0_rvalid = tag2_r[1] & ~tag2_r[0];
    assign p1_rvalid = tag2_r[1] &  tag2_r[0];
    assign p0_rdata  = data_out_io;
    assign p1_rdata  = data_out_io;

endmodule
